// File: rtl/mips_pkg.sv
// Shared MIPS core constants.
//   WB_SEL_*   : write-back source select encodings (3 is reserved and behaves as ALU)
//   MEM_SIZE_* : load size encodings (3 behaves as word)
//   REG_ZERO   : hard-wired zero register, never written
//   REG_RA     : return-address register used by jal
package mips_pkg;

    localparam logic [1:0] WB_SEL_ALU  = 2'd0;
    localparam logic [1:0] WB_SEL_MEM  = 2'd1;
    localparam logic [1:0] WB_SEL_LINK = 2'd2;

    localparam logic [1:0] MEM_SIZE_B  = 2'd0;
    localparam logic [1:0] MEM_SIZE_H  = 2'd1;
    localparam logic [1:0] MEM_SIZE_W  = 2'd2;

    localparam logic [4:0] REG_ZERO    = 5'd0;
    localparam logic [4:0] REG_RA      = 5'd31;

endpackage

// File: rtl/load_formatter.sv
// Load data formatter (purely combinational).
// Picks the addressed byte/halfword lane out of an aligned little-endian
// memory word, sign- or zero-extends it, and flags misaligned accesses.
// Ports:
//   rdata      in  32      aligned word from data memory
//   off        in  2       byte offset within the word
//   size       in  2       MEM_SIZE_B / MEM_SIZE_H / MEM_SIZE_W (3 = word)
//   is_signed  in  1       1 = sign-extend byte/half, 0 = zero-extend
//   value      out DATA_W  formatted load value
//   misaligned out 1       half at odd offset, or word at non-zero offset
module load_formatter
    import mips_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [31:0]       rdata,
    input  logic [1:0]        off,
    input  logic [1:0]        size,
    input  logic              is_signed,
    output logic [DATA_W-1:0] value,
    output logic              misaligned
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    assign byte_lane = rdata[{off, 3'b000} +: 8];
    // off[0] is ignored for the lane choice; an odd offset is reported as misaligned.
    assign half_lane = off[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        value      = '0;
        misaligned = 1'b0;
        case (size)
            MEM_SIZE_B: begin
                value = {{(DATA_W-8){is_signed & byte_lane[7]}}, byte_lane};
            end
            MEM_SIZE_H: begin
                value      = {{(DATA_W-16){is_signed & half_lane[15]}}, half_lane};
                misaligned = off[0];
            end
            default: begin
                value      = DATA_W'(rdata);
                misaligned = (off != 2'd0);
            end
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline register and write-back formatter.
// Captures one MEM-stage result per cycle, selects the write value
// (ALU / formatted load / link address), and drives the register file write
// port directly. The fwd_* bypass mirrors the write port so decode can see a
// value being written this cycle (reg_file reads are combinational and would
// otherwise return the stale value).
// Ports:
//   clk, rst                 core clock, async active-high reset
//   in_valid .. in_link_addr MEM-stage instruction payload
//   flush                    drop the instruction being captured this cycle
//   write_address/write_data/reg_write_en   register file write port
//   fwd_valid/fwd_addr/fwd_data             bypass copy of the write port
//   exc_misaligned           one-cycle pulse for a misaligned load in WB
//   retire_count             instructions retired through WB (wraps)
module mem_wb_stage
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_reg_write,
    input  logic [ADDR_W-1:0] in_dest,
    input  logic [1:0]        in_wb_sel,
    input  logic [1:0]        in_mem_size,
    input  logic              in_mem_signed,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [DATA_W-1:0] in_mem_rdata,
    input  logic [DATA_W-1:0] in_link_addr,
    input  logic              flush,
    output logic [ADDR_W-1:0] write_address,
    output logic [DATA_W-1:0] write_data,
    output logic              reg_write_en,
    output logic              fwd_valid,
    output logic [ADDR_W-1:0] fwd_addr,
    output logic [DATA_W-1:0] fwd_data,
    output logic              exc_misaligned,
    output logic [31:0]       retire_count
);

    logic [DATA_W-1:0] load_value;
    logic              load_misaligned;
    logic [DATA_W-1:0] sel_data;
    logic              sel_misaligned;

    logic              wb_valid;
    logic              wb_reg_write;
    logic              wb_misaligned;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic [31:0]       retire_cnt;

    load_formatter #(
        .DATA_W (DATA_W)
    ) u_load_formatter (
        .rdata      (in_mem_rdata[31:0]),
        .off        (in_alu_result[1:0]),
        .size       (in_mem_size),
        .is_signed  (in_mem_signed),
        .value      (load_value),
        .misaligned (load_misaligned)
    );

    always_comb begin
        sel_data       = in_alu_result;
        sel_misaligned = 1'b0;
        case (in_wb_sel)
            WB_SEL_MEM: begin
                sel_data       = load_value;
                // Only loads can be misaligned; ALU results with odd low bits are ordinary data.
                sel_misaligned = load_misaligned;
            end
            WB_SEL_LINK: sel_data = in_link_addr;
            default:     sel_data = in_alu_result;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid      <= 1'b0;
            wb_reg_write  <= 1'b0;
            wb_misaligned <= 1'b0;
            wb_addr       <= '0;
            wb_data       <= '0;
        end else begin
            wb_valid <= in_valid & ~flush;
            if (in_valid) begin
                wb_reg_write  <= in_reg_write;
                wb_misaligned <= sel_misaligned;
                wb_addr       <= in_dest;
                wb_data       <= sel_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retire_cnt <= '0;
        end else if (wb_valid && !wb_misaligned) begin
            retire_cnt <= retire_cnt + 32'd1;
        end
    end

    assign write_address  = wb_addr;
    assign write_data     = wb_data;
    assign reg_write_en   = wb_valid & wb_reg_write & (wb_addr != ADDR_W'(REG_ZERO)) & ~wb_misaligned;
    assign exc_misaligned = wb_valid & wb_misaligned;
    assign retire_count   = retire_cnt;

    assign fwd_valid = reg_write_en;
    assign fwd_addr  = write_address;
    assign fwd_data  = write_data;

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;
    import mips_pkg::*;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_reg_write;
    logic [4:0]  in_dest;
    logic [1:0]  in_wb_sel;
    logic [1:0]  in_mem_size;
    logic        in_mem_signed;
    logic [31:0] in_alu_result;
    logic [31:0] in_mem_rdata;
    logic [31:0] in_link_addr;
    logic        flush;
    logic [4:0]  write_address;
    logic [31:0] write_data;
    logic        reg_write_en;
    logic        fwd_valid;
    logic [4:0]  fwd_addr;
    logic [31:0] fwd_data;
    logic        exc_misaligned;
    logic [31:0] retire_count;

    int errors = 0;
    int checks = 0;

    mem_wb_stage dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_reg_write   (in_reg_write),
        .in_dest        (in_dest),
        .in_wb_sel      (in_wb_sel),
        .in_mem_size    (in_mem_size),
        .in_mem_signed  (in_mem_signed),
        .in_alu_result  (in_alu_result),
        .in_mem_rdata   (in_mem_rdata),
        .in_link_addr   (in_link_addr),
        .flush          (flush),
        .write_address  (write_address),
        .write_data     (write_data),
        .reg_write_en   (reg_write_en),
        .fwd_valid      (fwd_valid),
        .fwd_addr       (fwd_addr),
        .fwd_data       (fwd_data),
        .exc_misaligned (exc_misaligned),
        .retire_count   (retire_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Strobe side: write enable, bypass valid and exception pulse.
    task automatic check_strobe(input string tag, input logic en, input logic exc);
        check({tag, ".en"},  {31'd0, reg_write_en},   {31'd0, en});
        check({tag, ".fv"},  {31'd0, fwd_valid},      {31'd0, en});
        check({tag, ".exc"}, {31'd0, exc_misaligned}, {31'd0, exc});
    endtask

    // Payload side: write port and bypass copy.
    task automatic check_payload(input string tag, input logic [4:0] addr, input logic [31:0] data);
        check({tag, ".addr"},  {27'd0, write_address}, {27'd0, addr});
        check({tag, ".data"},  write_data,             data);
        check({tag, ".faddr"}, {27'd0, fwd_addr},      {27'd0, addr});
        check({tag, ".fdata"}, fwd_data,               data);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid     = 1'b0;
        in_reg_write = 1'b0;
        flush        = 1'b0;
    endtask

    task automatic issue(input logic rw, input logic [4:0] dest, input logic [1:0] sel,
                         input logic [1:0] size, input logic sgn, input logic [31:0] alu,
                         input logic [31:0] rdata, input logic [31:0] link, input logic fl);
        in_valid      = 1'b1;
        in_reg_write  = rw;
        in_dest       = dest;
        in_wb_sel     = sel;
        in_mem_size   = size;
        in_mem_signed = sgn;
        in_alu_result = alu;
        in_mem_rdata  = rdata;
        in_link_addr  = link;
        flush         = fl;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        in_dest = '0; in_wb_sel = '0; in_mem_size = '0; in_mem_signed = 1'b0;
        in_alu_result = '0; in_mem_rdata = '0; in_link_addr = '0;
        tick();
        tick();
        check_strobe("reset", 1'b0, 1'b0);
        check_payload("reset", 5'd0, 32'h0);
        check("reset.cnt", retire_count, 32'd0);
        rst = 1'b0;

        // ALU write
        issue(1'b1, 5'd9, WB_SEL_ALU, MEM_SIZE_W, 1'b0, 32'h1234_5678, 32'h0, 32'h0, 1'b0);
        tick();
        check_strobe("alu", 1'b1, 1'b0);
        check_payload("alu", 5'd9, 32'h1234_5678);
        check("alu.cnt_wb", retire_count, 32'd0);
        idle();
        tick();
        check("alu.cnt", retire_count, 32'd1);
        check_strobe("alu.after", 1'b0, 1'b0);

        // Back-to-back loads to the same destination, rdata = 0x80FF_7F01
        issue(1'b1, 5'd5, WB_SEL_MEM, MEM_SIZE_B, 1'b1, 32'h0000_1002, 32'h80FF_7F01, 32'h0, 1'b0);
        tick();
        check_strobe("lb", 1'b1, 1'b0);
        check_payload("lb", 5'd5, 32'hFFFF_FFFF);
        check("lb.cnt", retire_count, 32'd1);
        issue(1'b1, 5'd5, WB_SEL_MEM, MEM_SIZE_B, 1'b0, 32'h0000_1003, 32'h80FF_7F01, 32'h0, 1'b0);
        tick();
        check_payload("lbu", 5'd5, 32'h0000_0080);
        check("lbu.cnt", retire_count, 32'd2);
        issue(1'b1, 5'd5, WB_SEL_MEM, MEM_SIZE_H, 1'b1, 32'h0000_1002, 32'h80FF_7F01, 32'h0, 1'b0);
        tick();
        check_payload("lh", 5'd5, 32'hFFFF_80FF);
        check("lh.cnt", retire_count, 32'd3);
        issue(1'b1, 5'd5, WB_SEL_MEM, MEM_SIZE_H, 1'b0, 32'h0000_1000, 32'h80FF_7F01, 32'h0, 1'b0);
        tick();
        check_payload("lhu", 5'd5, 32'h0000_7F01);
        check("lhu.cnt", retire_count, 32'd4);
        issue(1'b1, 5'd5, WB_SEL_MEM, MEM_SIZE_W, 1'b1, 32'h0000_1000, 32'h80FF_7F01, 32'h0, 1'b0);
        tick();
        check_strobe("lw", 1'b1, 1'b0);
        check_payload("lw", 5'd5, 32'h80FF_7F01);
        check("lw.cnt", retire_count, 32'd5);
        idle();
        tick();
        check("loads.cnt", retire_count, 32'd6);

        // Misaligned word load
        issue(1'b1, 5'd16, WB_SEL_MEM, MEM_SIZE_W, 1'b0, 32'h0000_1001, 32'h80FF_7F01, 32'h0, 1'b0);
        tick();
        check_strobe("lw_mis", 1'b0, 1'b1);
        check("lw_mis.addr", {27'd0, write_address}, 32'd16);
        idle();
        tick();
        check_strobe("lw_mis.after", 1'b0, 1'b0);
        check("lw_mis.cnt", retire_count, 32'd6);

        // Misaligned half load
        issue(1'b1, 5'd16, WB_SEL_MEM, MEM_SIZE_H, 1'b1, 32'h0000_1001, 32'h80FF_7F01, 32'h0, 1'b0);
        tick();
        check_strobe("lh_mis", 1'b0, 1'b1);
        idle();
        tick();
        check_strobe("lh_mis.after", 1'b0, 1'b0);
        check("lh_mis.cnt", retire_count, 32'd6);

        // Odd ALU result is not a misaligned load
        issue(1'b1, 5'd4, WB_SEL_ALU, MEM_SIZE_W, 1'b0, 32'h0000_0003, 32'h0, 32'h0, 1'b0);
        tick();
        check_strobe("alu_odd", 1'b1, 1'b0);
        check_payload("alu_odd", 5'd4, 32'h0000_0003);
        idle();
        tick();
        check("alu_odd.cnt", retire_count, 32'd7);

        // Write to $0: suppressed but retires
        issue(1'b1, REG_ZERO, WB_SEL_ALU, MEM_SIZE_W, 1'b0, 32'hDEAD_BEEF, 32'h0, 32'h0, 1'b0);
        tick();
        check_strobe("zero", 1'b0, 1'b0);
        idle();
        tick();
        check("zero.cnt", retire_count, 32'd8);

        // Flush wins over in_valid
        issue(1'b1, 5'd9, WB_SEL_ALU, MEM_SIZE_W, 1'b0, 32'h5555_AAAA, 32'h0, 32'h0, 1'b1);
        tick();
        check_strobe("flush", 1'b0, 1'b0);
        idle();
        tick();
        check("flush.cnt", retire_count, 32'd8);

        // Flushed misaligned load raises no exception
        issue(1'b1, 5'd9, WB_SEL_MEM, MEM_SIZE_W, 1'b0, 32'h0000_0002, 32'h0, 32'h0, 1'b1);
        tick();
        check_strobe("flush_mis", 1'b0, 1'b0);
        idle();

        // jal link write
        issue(1'b1, REG_RA, WB_SEL_LINK, MEM_SIZE_W, 1'b0, 32'h0000_0000, 32'h0, 32'h0040_0008, 1'b0);
        tick();
        check_strobe("jal", 1'b1, 1'b0);
        check_payload("jal", 5'd31, 32'h0040_0008);
        idle();
        tick();
        check("jal.cnt", retire_count, 32'd9);

        // Counter wrap
        force dut.retire_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.retire_cnt;
        issue(1'b1, 5'd3, WB_SEL_ALU, MEM_SIZE_W, 1'b0, 32'h0000_0077, 32'h0, 32'h0, 1'b0);
        tick();
        check("wrap.pre", retire_count, 32'hFFFF_FFFF);
        idle();
        tick();
        check("wrap.cnt", retire_count, 32'd0);

        // Reset mid-stream drops the in-flight write
        issue(1'b1, 5'd7, WB_SEL_ALU, MEM_SIZE_W, 1'b0, 32'h0000_AAAA, 32'h0, 32'h0, 1'b0);
        tick();
        check_strobe("pre_rst", 1'b1, 1'b0);
        idle();
        #2;
        rst = 1'b1;
        #1;
        check_strobe("mid_rst", 1'b0, 1'b0);
        check_payload("mid_rst", 5'd0, 32'h0);
        check("mid_rst.cnt", retire_count, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        check_strobe("post_rst", 1'b0, 1'b0);
        check("post_rst.cnt", retire_count, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
